jk_cmd_frontend: RTL and testbench
==================================

JK_CMD_FRONTEND -- requirements
Module: jk_cmd_frontend

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, meaning the number of consecutive stable synchronized samples required to accept a new button level (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning the width of the command counter.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset: asynchronous, active-low.
REQ-005 SHALL have port btn_set, input, 1, meaning the raw asynchronous set button (active-high).
REQ-006 SHALL have port btn_clr, input, 1, meaning the raw asynchronous clear button (active-high).
REQ-007 SHALL have port btn_tgl, input, 1, meaning the raw asynchronous toggle button (active-high).
REQ-008 SHALL have port en, output, 1, meaning a one-cycle command strobe to the downstream JK stage.
REQ-009 SHALL have ports J and K, output, 1 each, meaning the command encoding that is valid while en=1.
REQ-010 SHALL have port conflict, output, 1, meaning a sticky flag that at least one simultaneous-command collision occurred.
REQ-011 SHALL have port cmd_cnt, output, CNT_W, meaning the number of strobes issued, modulo 2^CNT_W.

Function
REQ-012 SHALL pass each raw button through its own 2-flop synchronizer; no raw input reaches any other logic.
REQ-013 SHALL give each channel a debounce counter, ceil(log2(DEB_CYCLES)) bits wide, plus a debounced level deb.
- sync2 == deb: counter cleared to 0.
- sync2 != deb and counter < DEB_CYCLES-1: counter +1.
- sync2 != deb and counter == DEB_CYCLES-1: deb <= sync2, counter <= 0.
REQ-014 SHALL reset the counter to 0 on any single-sample glitch back to the deb level, so that only DEB_CYCLES consecutive differing samples change deb.
REQ-015 SHALL detect a rise as deb=1 and deb_prev=0 (deb_prev is deb registered one cycle); falling edges SHALL produce no command.
REQ-016 SHALL map a rise to a command, registered: set gives J=1,K=0; clr gives J=0,K=1; tgl gives J=1,K=1; each with en=1 for exactly one cycle.
REQ-017 SHALL hold en=0, J=0, K=0 in every cycle without a command (J=K=0 is never strobed).
REQ-018 SHALL resolve rises on more than one channel in the same cycle by priority set > clr > tgl: issue only the winner, drop the others, and set conflict=1 in the same cycle as the strobe.
REQ-019 SHALL keep conflict at 1 until reset.
REQ-020 SHALL increment cmd_cnt by 1 with each strobe, registered with en, wrapping from 2^CNT_W-1 to 0 without a flag.
REQ-021 SHALL have latency such that a raw level first captured by the synchronizer at edge N, then held stable, gives en=1 in the cycle after edge N+DEB_CYCLES+2.
REQ-022 SHALL issue one strobe per debounced press, however long the button is held.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously clear all synchronizer flops, counters, deb, deb_prev, en, J, K, conflict and cmd_cnt to 0.
REQ-024 SHALL produce no strobe after rst_n deasserts while a button is still held; that button is treated as a new press and gives one strobe after the full latency of REQ-021.
REQ-025 SHALL discard any debounce in progress when reset is asserted mid-count; no partial count survives reset.

Verification (DEB_CYCLES=4 unless stated)
REQ-026 SHALL be checked with: btn_set high, sampled at edge 10 and held 20 cycles -> en=1, J=1, K=0 only in the cycle after edge 16; cmd_cnt 0->1.
REQ-027 SHALL be checked with: btn_clr high for 3 cycles, then low, repeated 5 times -> en is never 1; cmd_cnt stays 0.
REQ-028 SHALL be checked with: btn_set and btn_tgl rising on the same edge -> a single strobe with J=1, K=0; conflict=1 from the same cycle onward.
REQ-029 SHALL be checked with: btn_tgl pressed and released 256 times, CNT_W=8 -> 256 strobes with J=K=1; cmd_cnt returns to 0.
REQ-030 SHALL be checked with: rst_n pulsed low while btn_clr is held mid-debounce -> all outputs 0 during reset; exactly one strobe with J=0, K=1 at DEB_CYCLES+3 edges after release of reset.

Source files
------------

// File: rtl/jk_cmd_frontend.sv
// Button front end for a JK stage: synchronizes and debounces three raw buttons,
// turns debounced rising edges into one-cycle J/K command strobes with fixed priority.
module jk_cmd_frontend #(
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_set,
    input  logic             btn_clr,
    input  logic             btn_tgl,
    output logic             en,
    output logic             J,
    output logic             K,
    output logic             conflict,
    output logic [CNT_W-1:0] cmd_cnt
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DMAX = DW'(DEB_CYCLES - 1);

    // Channel order everywhere: [0]=set, [1]=clr, [2]=tgl.
    logic [2:0]    raw;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    deb;
    logic [2:0]    deb_prev;
    logic [2:0]    rise;
    logic [DW-1:0] dcnt [3];

    logic          cmd_en;
    logic          cmd_j;
    logic          cmd_k;
    logic          collide;

    assign raw = {btn_tgl, btn_clr, btn_set};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Any sample matching deb restarts the count, so only an unbroken run
    // of DEB_CYCLES differing samples moves deb.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            for (int i = 0; i < 3; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DMAX) begin
                    deb[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_prev <= '0;
        end else begin
            deb_prev <= deb;
        end
    end

    assign rise = deb & ~deb_prev;

    always_comb begin
        cmd_en  = 1'b0;
        cmd_j   = 1'b0;
        cmd_k   = 1'b0;
        collide = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);
        if (rise[0]) begin
            cmd_en = 1'b1;
            cmd_j  = 1'b1;
        end else if (rise[1]) begin
            cmd_en = 1'b1;
            cmd_k  = 1'b1;
        end else if (rise[2]) begin
            cmd_en = 1'b1;
            cmd_j  = 1'b1;
            cmd_k  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            J        <= 1'b0;
            K        <= 1'b0;
            conflict <= 1'b0;
            cmd_cnt  <= '0;
        end else begin
            en <= cmd_en;
            J  <= cmd_j;
            K  <= cmd_k;
            if (collide) begin
                conflict <= 1'b1;
            end
            if (cmd_en) begin
                cmd_cnt <= cmd_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_jk_cmd_frontend.sv
// Directed bench for jk_cmd_frontend (DEB_CYCLES=4, CNT_W=8): drivers push expected
// strobes (edge, conflict, J, K, count) into a queue; a negedge monitor pops and compares.
module tb_jk_cmd_frontend;

    localparam int DEB   = 4;
    localparam int CNT_W = 8;
    localparam int QW    = 27;   // [26:11] edge, [10] conflict, [9] J, [8] K, [7:0] cmd_cnt

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             btn_set = 1'b0;
    logic             btn_clr = 1'b0;
    logic             btn_tgl = 1'b0;
    logic             en;
    logic             J;
    logic             K;
    logic             conflict;
    logic [CNT_W-1:0] cmd_cnt;

    int               edge_cnt = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    logic [QW-1:0]    exp_q[$];
    logic [7:0]       exp_cnt = '0;
    logic             exp_conflict = 1'b0;

    jk_cmd_frontend #(.DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_set  (btn_set),
        .btn_clr  (btn_clr),
        .btn_tgl  (btn_tgl),
        .en       (en),
        .J        (J),
        .K        (K),
        .conflict (conflict),
        .cmd_cnt  (cmd_cnt)
    );

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Drive a button mask for 'high' sampled cycles, then release for 'low'.
    task automatic press(input logic [2:0] m, input int high, input int low, input bit expect_cmd);
        logic j;
        logic k;
        int   cap;
        @(negedge clk);
        {btn_tgl, btn_clr, btn_set} = m;
        cap = edge_cnt + 1;
        if (expect_cmd) begin
            if (m[0]) begin
                j = 1'b1; k = 1'b0;
            end else if (m[1]) begin
                j = 1'b0; k = 1'b1;
            end else begin
                j = 1'b1; k = 1'b1;
            end
            if ((m == 3'b011) || (m == 3'b101) || (m == 3'b110) || (m == 3'b111))
                exp_conflict = 1'b1;
            exp_cnt = exp_cnt + 8'd1;
            exp_q.push_back({16'(cap + DEB + 2), exp_conflict, j, k, exp_cnt});
        end
        repeat (high) @(negedge clk);
        {btn_tgl, btn_clr, btn_set} = 3'b000;
        repeat (low) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, int'(en), 0);
        check({tag, "_j"}, int'(J), 0);
        check({tag, "_k"}, int'(K), 0);
        check({tag, "_conflict"}, int'(conflict), 0);
        check({tag, "_cnt"}, int'(cmd_cnt), 0);
    endtask

    task automatic plain_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_cnt = '0;
        exp_conflict = 1'b0;
        #1 check_reset_outputs("plain_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [QW-1:0] e;
        if (rst_n) begin
            if (exp_q.size() > 0 && int'(exp_q[0][26:11]) < edge_cnt) begin
                e = exp_q.pop_front();
                check("strobe_missing", 0, int'(e[26:11]));
            end
            if (en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobe_edge", edge_cnt, int'(e[26:11]));
                    check("strobe_conflict", int'(conflict), int'(e[10]));
                    check("strobe_j", int'(J), int'(e[9]));
                    check("strobe_k", int'(K), int'(e[8]));
                    check("strobe_cnt", int'(cmd_cnt), int'(e[7:0]));
                end
            end else begin
                check("idle_jk", int'({J, K}), 0);
            end
        end
    end

    initial begin
        #2 check_reset_outputs("por");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Long hold: exactly one set strobe.
        press(3'b001, 20, 10, 1'b1);

        // Short clr pulses never reach the debounce threshold.
        for (int i = 0; i < 5; i++) press(3'b010, 3, 2, 1'b0);
        press(3'b010, 3, 1, 1'b0);
        press(3'b010, 3, 10, 1'b0);
        check("glitch_cnt", int'(cmd_cnt), 1);

        press(3'b010, 8, 10, 1'b1);
        check("no_conflict_yet", int'(conflict), 0);

        // Simultaneous presses: priority winner, sticky conflict.
        press(3'b101, 8, 10, 1'b1);
        press(3'b110, 8, 10, 1'b1);
        press(3'b100, 8, 10, 1'b1);
        check("conflict_sticky", int'(conflict), 1);

        // Reset in the middle of a clr debounce, button still held.
        @(negedge clk);
        btn_clr = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_cnt = '0;
        exp_conflict = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        exp_cnt = 8'd1;
        exp_q.push_back({16'(edge_cnt + DEB + 3), 1'b0, 1'b0, 1'b1, exp_cnt});
        repeat (15) @(negedge clk);
        btn_clr = 1'b0;
        repeat (10) @(negedge clk);

        // 256 toggles from a clean reset wrap the counter back to zero.
        plain_reset();
        for (int i = 0; i < 256; i++) press(3'b100, 6, 7, 1'b1);
        repeat (5) @(negedge clk);
        check("wrap_cnt", int'(cmd_cnt), 0);
        check("wrap_conflict", int'(conflict), 0);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
